// File: rtl/spi_ctrl_pkg.sv
// Shared encodings for the SPI transaction scheduler: FSM states, byte width
// and the round-robin pointer increment.
package spi_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } spi_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, searching upward with wrap, returned as one-hot and as an index.
module spi_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_win_oh,
    output logic [IDX_W-1:0] o_win_idx,
    output logic             o_win_valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any branch, so no latch can be inferred.
        o_win_oh    = '0;
        o_win_idx   = '0;
        o_win_valid = 1'b0;
        w_cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = IDX_W'((int'(i_ptr) + i) % N_REQ);
            if (!o_win_valid && i_req[w_cand]) begin
                o_win_valid      = 1'b1;
                o_win_idx        = w_cand;
                o_win_oh[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI byte engine between N_REQ requesters, one chip-select each,
// round-robin per transaction. SPI_TIMEOUT_EN adds a per-byte eng_done timeout.
module spi_txn_scheduler
    import spi_ctrl_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int LEN_W    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*LEN_W-1:0]    req_len,
    input  logic [N_REQ*BYTE_W-1:0]   req_tx,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          tx_ack,
    output logic [N_REQ-1:0]          rx_valid,
    output logic [BYTE_W-1:0]         rx_data,
    output logic [N_REQ-1:0]          done,
    output logic                      busy,
    output logic [N_REQ-1:0]          ss_n,
    output logic                      eng_start,
    output logic [BYTE_W-1:0]         eng_tx,
    input  logic                      eng_busy,
    input  logic                      eng_done,
    input  logic [BYTE_W-1:0]         eng_rx,
    output logic                      err
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W  = LEN_W + 1;
    localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    logic [LEN_W-1:0]  w_len_arr [N_REQ];
    logic [BYTE_W-1:0] w_tx_arr  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign w_len_arr[g] = req_len[g*LEN_W +: LEN_W];
        assign w_tx_arr[g]  = req_tx[g*BYTE_W +: BYTE_W];
    end

    spi_state_e        r_state, w_state_nx;
    logic [IDX_W-1:0]  r_idx, w_idx_nx;
    logic [IDX_W-1:0]  r_ptr, w_ptr_nx;
    logic [LEN_W-1:0]  r_len, w_len_nx;
    logic [CNT_W-1:0]  r_byte_cnt, w_byte_cnt_nx;
    logic [PH_W-1:0]   r_ph_cnt, w_ph_cnt_nx;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nx;
    logic [N_REQ-1:0]  r_ss_n, w_ss_n_nx;
    logic [N_REQ-1:0]  r_tx_ack, w_tx_ack_nx;
    logic [N_REQ-1:0]  r_rx_valid, w_rx_valid_nx;
    logic [N_REQ-1:0]  r_done, w_done_nx;
    logic [BYTE_W-1:0] r_rx_data, w_rx_data_nx;
    logic [BYTE_W-1:0] r_eng_tx, w_eng_tx_nx;
    logic              r_eng_start, w_eng_start_nx;
    logic              r_busy;

    logic [N_REQ-1:0]  w_win_oh;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_win_valid;

`ifdef SPI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nx;
    logic              r_err, w_err_nx;
`endif

    spi_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req       (req),
        .i_ptr       (r_ptr),
        .o_win_oh    (w_win_oh),
        .o_win_idx   (w_win_idx),
        .o_win_valid (w_win_valid)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_ptr_nx       = r_ptr;
        w_len_nx       = r_len;
        w_byte_cnt_nx  = r_byte_cnt;
        w_ph_cnt_nx    = r_ph_cnt;
        w_gnt_nx       = r_gnt;
        w_ss_n_nx      = r_ss_n;
        w_tx_ack_nx    = '0;
        w_rx_valid_nx  = '0;
        w_done_nx      = '0;
        w_rx_data_nx   = r_rx_data;
        w_eng_tx_nx    = r_eng_tx;
        w_eng_start_nx = 1'b0;
`ifdef SPI_TIMEOUT_EN
        w_to_cnt_nx    = r_to_cnt;
        w_err_nx       = r_err;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_win_valid && !eng_busy) begin
                    w_state_nx    = ST_SETUP;
                    w_idx_nx      = w_win_idx;
                    w_gnt_nx      = w_win_oh;
                    w_ss_n_nx     = ~w_win_oh;
                    w_len_nx      = w_len_arr[w_win_idx];
                    w_byte_cnt_nx = '0;
                    w_ph_cnt_nx   = '0;
                end
            end
            ST_SETUP: begin
                if (r_ph_cnt == PH_W'(CS_SETUP - 1)) begin
                    w_state_nx = ST_XFER;
                end else begin
                    w_ph_cnt_nx = r_ph_cnt + 1'b1;
                end
            end
            ST_XFER: begin
                w_state_nx = ST_WAIT;
`ifdef SPI_TIMEOUT_EN
                w_to_cnt_nx = '0;
`endif
            end
            ST_WAIT: begin
                if (eng_done) begin
                    w_rx_data_nx           = eng_rx;
                    w_rx_valid_nx[r_idx]   = 1'b1;
                    w_byte_cnt_nx          = r_byte_cnt + 1'b1;
                    // r_byte_cnt is the count before this byte, so equality marks the last one.
                    if (r_byte_cnt == {1'b0, r_len}) begin
                        w_state_nx  = ST_HOLD;
                        w_ss_n_nx   = '1;
                        w_ph_cnt_nx = '0;
                    end else begin
                        w_state_nx = ST_XFER;
                    end
                end
`ifdef SPI_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                    w_err_nx    = 1'b1;
                    w_state_nx  = ST_HOLD;
                    w_ss_n_nx   = '1;
                    w_ph_cnt_nx = '0;
                end else begin
                    w_to_cnt_nx = r_to_cnt + 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (r_ph_cnt == PH_W'(CS_HOLD - 1)) begin
                    w_state_nx       = ST_IDLE;
                    w_done_nx[r_idx] = 1'b1;
                    w_gnt_nx         = '0;
                    w_ptr_nx         = IDX_W'(rr_next(int'(r_idx), N_REQ));
                end else begin
                    w_ph_cnt_nx = r_ph_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_gnt_nx   = '0;
                w_ss_n_nx  = '1;
            end
        endcase

        // XFER lasts exactly one cycle, so entering it is the byte-start event.
        if (w_state_nx == ST_XFER) begin
            w_eng_start_nx     = 1'b1;
            w_tx_ack_nx[r_idx] = 1'b1;
            w_eng_tx_nx        = w_tx_arr[r_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_ptr       <= '0;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_ph_cnt    <= '0;
            r_gnt       <= '0;
            r_ss_n      <= '1;
            r_tx_ack    <= '0;
            r_rx_valid  <= '0;
            r_done      <= '0;
            r_rx_data   <= '0;
            r_eng_tx    <= '0;
            r_eng_start <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SPI_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments let every register update from the same pre-edge values.
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_ptr       <= w_ptr_nx;
            r_len       <= w_len_nx;
            r_byte_cnt  <= w_byte_cnt_nx;
            r_ph_cnt    <= w_ph_cnt_nx;
            r_gnt       <= w_gnt_nx;
            r_ss_n      <= w_ss_n_nx;
            r_tx_ack    <= w_tx_ack_nx;
            r_rx_valid  <= w_rx_valid_nx;
            r_done      <= w_done_nx;
            r_rx_data   <= w_rx_data_nx;
            r_eng_tx    <= w_eng_tx_nx;
            r_eng_start <= w_eng_start_nx;
            r_busy      <= (w_state_nx != ST_IDLE);
`ifdef SPI_TIMEOUT_EN
            r_to_cnt    <= w_to_cnt_nx;
            r_err       <= w_err_nx;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign ss_n      = r_ss_n;
    assign tx_ack    = r_tx_ack;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign done      = r_done;
    assign busy      = r_busy;
    assign eng_start = r_eng_start;
    assign eng_tx    = r_eng_tx;
`ifdef SPI_TIMEOUT_EN
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler with a behavioural byte engine and
// requester byte sources; covers both builds of SPI_TIMEOUT_EN.
module tb_spi_txn_scheduler;

    localparam int ENG_DLY = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [31:0] req_tx;
    logic [3:0]  gnt, tx_ack, rx_valid, done, ss_n;
    logic [7:0]  rx_data, eng_tx, eng_rx;
    logic        busy, eng_start, eng_busy, eng_done, err;
    logic        eng_en;

    spi_txn_scheduler #(
        .N_REQ    (4),
        .LEN_W    (4),
        .CS_SETUP (2),
        .CS_HOLD  (2),
        .TIMEOUT  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .req_tx    (req_tx),
        .gnt       (gnt),
        .tx_ack    (tx_ack),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .done      (done),
        .busy      (busy),
        .ss_n      (ss_n),
        .eng_start (eng_start),
        .eng_tx    (eng_tx),
        .eng_busy  (eng_busy),
        .eng_done  (eng_done),
        .eng_rx    (eng_rx),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tx_byte(input int i, input int n);
        return 8'((i * 64 + n * 3 + 1) & 255);
    endfunction

    // Behavioural byte engine: eng_done ENG_DLY cycles after eng_start, rx = tx ^ A5.
    int         cd;
    logic [7:0] rx_val;
    initial begin
        eng_busy = 1'b0;
        eng_done = 1'b0;
        eng_rx   = 8'h00;
        cd       = 0;
        rx_val   = 8'h00;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eng_done = eng_en;
                    eng_busy = 1'b0;
                    eng_rx   = rx_val;
                end
            end
            if (eng_start) begin
                cd       = ENG_DLY;
                eng_busy = 1'b1;
                rx_val   = eng_tx ^ 8'hA5;
            end
        end
    end

    // Requester byte sources and event counters.
    int         n_ack [4];
    int         n_rxv [4];
    int         n_done[4];
    int         sent  [4];
    int         n_start = 0, n_tx_bad = 0, n_rx_bad = 0, n_ss_bad = 0;
    int         q_grant[$];
    logic [7:0] last_tx = 8'h00;
    logic [3:0] prev_gnt = 4'h0;
    initial begin
        for (int i = 0; i < 4; i++) begin
            n_ack[i] = 0; n_rxv[i] = 0; n_done[i] = 0; sent[i] = 0;
            req_tx[i*8 +: 8] = tx_byte(i, 0);
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rx_valid[i]) begin
                    n_rxv[i]++;
                    if (rx_data !== (last_tx ^ 8'hA5)) n_rx_bad++;
                end
                if (tx_ack[i]) begin
                    n_ack[i]++;
                    if (eng_tx !== tx_byte(i, sent[i]) || !eng_start) n_tx_bad++;
                    sent[i]++;
                    req_tx[i*8 +: 8] = tx_byte(i, sent[i]);
                end
                if (done[i]) n_done[i]++;
            end
            if (eng_start) begin
                n_start++;
                last_tx = eng_tx;
            end
            if (gnt != 4'h0 && prev_gnt == 4'h0)
                for (int i = 0; i < 4; i++) if (gnt[i]) q_grant.push_back(i);
            prev_gnt = gnt;
            if (!$onehot0(gnt) || !$onehot0(~ss_n) || ((~ss_n & ~gnt) != 4'h0)) n_ss_bad++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int seen = 0;
        int k    = 0;
        while (seen < n && k < budget) begin
            tick();
            k++;
            if (|done) seen++;
        end
        check(tag, seen, n);
    endtask

    function automatic int gl(input int k);
        if (k < q_grant.size()) return q_grant[k];
        return 99;
    endfunction

    int exp2[5] = '{0, 1, 2, 3, 0};
    int exp3[3] = '{3, 0, 3};
    int a0, r0, d0, d1, d2, d3, s0, gb, k;

    initial begin
        rst = 1'b1; req = 4'h0; req_len = 16'h0; eng_en = 1'b1;
        repeat (3) tick();
        check("rst_gnt", gnt, 4'h0);
        check("rst_ss_n", ss_n, 4'hF);
        check("rst_busy", busy, 1'b0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_eng_tx", eng_tx, 8'h00);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_done", done, 4'h0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);

        // 1: single 3-byte transaction on requester 1
        req_len = 16'h0020; req = 4'b0010;
        a0 = n_ack[1]; r0 = n_rxv[1]; d1 = n_done[1];
        tick();
        req = 4'h0;
        check("t1_gnt", gnt, 4'b0010);
        check("t1_ss_n", ss_n, 4'b1101);
        check("t1_busy", busy, 1'b1);
        check("t1_setup0", eng_start, 1'b0);
        tick();
        check("t1_setup1", eng_start, 1'b0);
        tick();
        check("t1_first_start", eng_start, 1'b1);
        check("t1_first_ack", tx_ack, 4'b0010);
        check("t1_first_tx", eng_tx, tx_byte(1, 0));
        wait_dones(1, 200, "t1_done_seen");
        check("t1_done_bit", done, 4'b0010);
        check("t1_ss_n_end", ss_n, 4'hF);
        check("t1_gnt_end", gnt, 4'h0);
        check("t1_acks", n_ack[1] - a0, 3);
        check("t1_rxv", n_rxv[1] - r0, 3);
        check("t1_dones", n_done[1] - d1, 1);
        tick();
        check("t1_idle", busy, 1'b0);

        // 2: all requesting from pointer 0, one byte each
        do_reset();
        req_len = 16'h0; req = 4'hF;
        gb = q_grant.size(); d0 = n_done[0]; d3 = n_done[3];
        wait_dones(5, 400, "t2_done_seen");
        req = 4'h0;
        for (int i = 0; i < 5; i++) check($sformatf("t2_grant%0d", i), gl(gb + i), exp2[i]);
        check("t2_done0", n_done[0] - d0, 2);
        check("t2_done3", n_done[3] - d3, 1);
        tick();
        check("t2_idle", busy, 1'b0);

        // 3: grant 3, then pointer wraps to 0 before 3 again
        gb = q_grant.size();
        req = 4'b1000;
        wait_dones(1, 200, "t3_done_a");
        req = 4'b1001;
        wait_dones(2, 300, "t3_done_b");
        req = 4'h0;
        for (int i = 0; i < 3; i++) check($sformatf("t3_grant%0d", i), gl(gb + i), exp3[i]);

        // 4: reset in WAIT of a 4-byte transaction
        tick();
        req_len = 16'h0003; req = 4'b0001;
        s0 = n_start;
        tick();
        req = 4'h0;
        k = 0;
        while (n_start < s0 + 2 && k < 200) begin tick(); k++; end
        check("t4_reach_wait", n_start - s0, 2);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_ss_n", ss_n, 4'hF);
        check("t4_busy", busy, 1'b0);
        check("t4_gnt", gnt, 4'h0);
        check("t4_rx_data", rx_data, 8'h00);
        check("t4_eng_start", eng_start, 1'b0);
        d0 = n_done[0];
        repeat (25) tick();
        check("t4_no_done", n_done[0] - d0, 0);
        check("t4_still_idle", busy, 1'b0);
        req_len = 16'h0; req = 4'b0100;
        d2 = n_done[2];
        tick();
        req = 4'h0;
        check("t4_fresh_gnt", gnt, 4'b0100);
        wait_dones(1, 200, "t4_fresh_done_seen");
        check("t4_fresh_done", n_done[2] - d2, 1);

        // 5: maximum length, 16 bytes
        tick();
        req_len = 16'h000F; req = 4'b0001;
        s0 = n_start; a0 = n_ack[0]; r0 = n_rxv[0]; d0 = n_done[0];
        tick();
        req = 4'h0;
        wait_dones(1, 800, "t5_done_seen");
        check("t5_starts", n_start - s0, 16);
        check("t5_acks", n_ack[0] - a0, 16);
        check("t5_rxv", n_rxv[0] - r0, 16);
        check("t5_dones", n_done[0] - d0, 1);

        // 6: engine never completes
        tick();
        eng_en = 1'b0; req_len = 16'h0; req = 4'b0010;
        d1 = n_done[1];
        tick();
        req = 4'h0;
        k = 0;
        while (!eng_start && k < 20) begin tick(); k++; end
        check("t6_start", eng_start, 1'b1);
`ifdef SPI_TIMEOUT_EN
        repeat (10) tick();
        check("t6_err_before", err, 1'b0);
        tick();
        check("t6_err_set", err, 1'b1);
        check("t6_hold_busy", busy, 1'b1);
        check("t6_hold_ss_n", ss_n, 4'hF);
        wait_dones(1, 10, "t6_done_seen");
        check("t6_done", n_done[1] - d1, 1);
        tick();
        check("t6_idle", busy, 1'b0);
        check("t6_err_sticky", err, 1'b1);
`else
        repeat (300) tick();
        check("t6_busy_stuck", busy, 1'b1);
        check("t6_err_zero", err, 1'b0);
        check("t6_no_done", n_done[1] - d1, 0);
`endif
        eng_en = 1'b1;
        do_reset();
        check("t6_err_cleared", err, 1'b0);
        check("t6_busy_cleared", busy, 1'b0);

        check("inv_ss_gnt", n_ss_bad, 0);
        check("inv_tx_bytes", n_tx_bad, 0);
        check("inv_rx_bytes", n_rx_bad, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
